// File: rtl/alu_div_arbiter.sv
// Shared iterative signed divider with round-robin arbitration among the
// thread ALUs of one core. One thread is granted at a time. Its operands go
// through a DATA_BITS-step restoring division, and the quotient is returned
// with a one-cycle done pulse to that thread.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   req          per-thread level request (bit i = thread i)
//   dividend     packed signed rs operands, thread i at [i*DATA_BITS +: DATA_BITS]
//   divisor      packed signed rt operands, same packing
//   done         one-cycle pulse to the granted thread when result is valid
//   result       signed quotient, valid only while a done bit is high
//   div_by_zero  high with done when the latched divisor was zero
//   busy         high in every state except IDLE
//   grant_id     index of the thread currently being served
module alu_div_arbiter #(
    parameter int unsigned THREADS   = 4,
    parameter int unsigned DATA_BITS = 8,
    localparam int unsigned ID_BITS  = $clog2(THREADS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [THREADS-1:0]             req,
    input  logic [THREADS*DATA_BITS-1:0]   dividend,
    input  logic [THREADS*DATA_BITS-1:0]   divisor,
    output logic [THREADS-1:0]             done,
    output logic [DATA_BITS-1:0]           result,
    output logic                           div_by_zero,
    output logic                           busy,
    output logic [ID_BITS-1:0]             grant_id
);

    // Magnitudes need one extra bit so that the most negative operand is representable.
    localparam int unsigned RW = DATA_BITS + 1;
    localparam int unsigned CW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t                 state, state_next;
    logic [ID_BITS-1:0]     rr_ptr, rr_ptr_next;
    logic [ID_BITS-1:0]     grant_id_next;
    logic [DATA_BITS-1:0]   op_a, op_a_next;
    logic [DATA_BITS-1:0]   op_b, op_b_next;
    logic                   neg, neg_next;
    logic                   dz, dz_next;
    logic [RW-1:0]          dvs_mag, dvs_mag_next;
    logic [RW-1:0]          rem, rem_next;
    logic [DATA_BITS-1:0]   quo, quo_next;
    logic [CW-1:0]          iter, iter_next;
    logic [THREADS-1:0]     done_next;
    logic [DATA_BITS-1:0]   result_next;
    logic                   div_by_zero_next;
    logic                   busy_next;

    // Per-thread operand views
    logic [DATA_BITS-1:0]   dvd_arr [THREADS];
    logic [DATA_BITS-1:0]   dvs_arr [THREADS];

    // Arbitration results
    logic                   found;
    logic [ID_BITS-1:0]     winner;
    logic [ID_BITS-1:0]     cand;

    // Magnitude conversion and restoring-step datapath
    logic [RW-1:0]          a_ext, b_ext;
    logic [RW-1:0]          a_mag, b_mag;
    logic [RW-1:0]          rem_sh;
    logic [RW:0]            trial;
    logic [RW-1:0]          rem_step;
    logic [DATA_BITS-1:0]   quo_step;
    logic [DATA_BITS-1:0]   quo_signed;

    // Unpack the operand buses into per-thread views
    always_comb begin
        for (int i = 0; i < int'(THREADS); i++) begin
            dvd_arr[i] = dividend[i*DATA_BITS +: DATA_BITS];
            dvs_arr[i] = divisor[i*DATA_BITS +: DATA_BITS];
        end
    end

    // Round-robin search starting at rr_ptr, wrapping modulo THREADS
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < int'(THREADS); k++) begin
            cand = ID_BITS'((int'(rr_ptr) + k) % int'(THREADS));
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Sign/magnitude conversion of the latched operands
    always_comb begin
        a_ext = {op_a[DATA_BITS-1], op_a};
        b_ext = {op_b[DATA_BITS-1], op_b};
        a_mag = op_a[DATA_BITS-1] ? (RW'(0) - a_ext) : a_ext;
        b_mag = op_b[DATA_BITS-1] ? (RW'(0) - b_ext) : b_ext;
    end

    // One restoring step. The remainder stays below the divisor magnitude,
    // so its top bit is always clear and can be dropped by the shift.
    always_comb begin
        rem_sh = {rem[RW-2:0], quo[DATA_BITS-1]};
        trial  = {1'b0, rem_sh} - {1'b0, dvs_mag};
        if (!trial[RW]) begin
            rem_step = trial[RW-1:0];
            quo_step = {quo[DATA_BITS-2:0], 1'b1};
        end else begin
            rem_step = rem_sh;
            quo_step = {quo[DATA_BITS-2:0], 1'b0};
        end
        quo_signed = neg ? (DATA_BITS'(0) - quo_step) : quo_step;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_next       = state;
        rr_ptr_next      = rr_ptr;
        grant_id_next    = grant_id;
        op_a_next        = op_a;
        op_b_next        = op_b;
        neg_next         = neg;
        dz_next          = dz;
        dvs_mag_next     = dvs_mag;
        rem_next         = rem;
        quo_next         = quo;
        iter_next        = iter;
        done_next        = '0;
        result_next      = '0;
        div_by_zero_next = 1'b0;
        busy_next        = 1'b0;

        case (state)
            S_IDLE: begin
                if (found) begin
                    state_next    = S_LOAD;
                    grant_id_next = winner;
                    op_a_next     = dvd_arr[winner];
                    op_b_next     = dvs_arr[winner];
                    if (winner == ID_BITS'(THREADS - 1)) begin
                        rr_ptr_next = '0;
                    end else begin
                        rr_ptr_next = winner + ID_BITS'(1);
                    end
                end
            end
            S_LOAD: begin
                state_next   = S_DIVIDE;
                neg_next     = op_a[DATA_BITS-1] ^ op_b[DATA_BITS-1];
                dvs_mag_next = b_mag;
                // Magnitude never exceeds 2**(DATA_BITS-1), so it fits unsigned in DATA_BITS
                quo_next     = a_mag[DATA_BITS-1:0];
                rem_next     = '0;
                dz_next      = (op_b == '0);
                iter_next    = '0;
            end
            S_DIVIDE: begin
                rem_next  = rem_step;
                quo_next  = quo_step;
                iter_next = iter + CW'(1);
                if (iter == CW'(DATA_BITS - 1)) begin
                    state_next              = S_DONE;
                    done_next[grant_id]     = 1'b1;
                    result_next             = dz ? '0 : quo_signed;
                    div_by_zero_next        = dz;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            op_a        <= '0;
            op_b        <= '0;
            neg         <= 1'b0;
            dz          <= 1'b0;
            dvs_mag     <= '0;
            rem         <= '0;
            quo         <= '0;
            iter        <= '0;
            done        <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_ptr_next;
            grant_id    <= grant_id_next;
            op_a        <= op_a_next;
            op_b        <= op_b_next;
            neg         <= neg_next;
            dz          <= dz_next;
            dvs_mag     <= dvs_mag_next;
            rem         <= rem_next;
            quo         <= quo_next;
            iter        <= iter_next;
            done        <= done_next;
            result      <= result_next;
            div_by_zero <= div_by_zero_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_alu_div_arbiter.sv
// Self-checking bench for alu_div_arbiter: expected results are pushed to a
// scoreboard when a request is driven and popped when done pulses.
module tb_alu_div_arbiter;

    localparam int T = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [T-1:0]   req;
    logic [T*W-1:0] dividend;
    logic [T*W-1:0] divisor;
    logic [T-1:0]   done;
    logic [W-1:0]   result;
    logic           div_by_zero;
    logic           busy;
    logic [1:0]     grant_id;

    typedef struct {
        int         thr;
        logic [7:0] res;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_div_arbiter #(.THREADS(T), .DATA_BITS(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .dividend    (dividend),
        .divisor     (divisor),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    // Reference quotient: SV integer division truncates toward zero
    function automatic exp_t model(int t, int a, int b);
        exp_t e;
        int   q;
        e.thr = t;
        if (b == 0) begin
            e.res = 8'h00;
            e.dz  = 1'b1;
        end else begin
            q     = a / b;
            e.res = 8'(q);
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    task automatic load_op(input int t, input int a, input int b);
        dividend[t*W +: W] = 8'(a);
        divisor[t*W +: W]  = 8'(b);
        sb.push_back(model(t, a, b));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req      = '0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL reset_done: got %b want 0000", done); end
        n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL reset_result: got %h want 00", result); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz: got %b want 0", div_by_zero); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        reset = 1'b0;
    endtask

    // Cycle-exact latency check on a single thread-0 divide
    task automatic test_basic();
        exp_t e;
        logic early;
        load_op(0, 100, 7);
        req = 4'b0001;
        @(negedge clk);   // cycle 1
        req = '0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_c1: got %b want 1", busy); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL basic_grant: got %0d want 0", grant_id); end
        early = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            if (done !== 4'b0000) early = 1'b1;
        end
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL basic_early_done: got %b want 0", early); end
        @(negedge clk);   // cycle 10
        e = sb.pop_front();
        n_cmp++; if (done !== 4'b0001) begin n_err++; $display("FAIL basic_done_c10: got %b want 0001", done); end
        n_cmp++; if (result !== e.res) begin n_err++; $display("FAIL basic_result: got %h want %h", result, e.res); end
        n_cmp++; if (div_by_zero !== e.dz) begin n_err++; $display("FAIL basic_dz: got %b want %b", div_by_zero, e.dz); end
        @(negedge clk);   // cycle 11
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_c11: got %b want 0", busy); end
        n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL basic_done_c11: got %b want 0000", done); end
    endtask

    // One request on thread t; checks the pulse and that it lasts one cycle
    task automatic test_single_op(input int t, input int a, input int b, input string name);
        exp_t         e;
        int           cyc;
        logic [T-1:0] want;
        load_op(t, a, b);
        req    = '0;
        req[t] = 1'b1;
        cyc    = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) req = '0;
            if (done !== 4'b0000) break;
        end
        if (done === 4'b0000) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got no done want done within 20 cycles", name);
            sb.delete();
            return;
        end
        e            = sb.pop_front();
        want         = '0;
        want[e.thr]  = 1'b1;
        n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL %s_latency: got %0d want 10", name, cyc); end
        n_cmp++; if (done !== want) begin n_err++; $display("FAIL %s_done: got %b want %b", name, done, want); end
        n_cmp++; if (result !== e.res) begin n_err++; $display("FAIL %s_result: got %h want %h", name, result, e.res); end
        n_cmp++; if (div_by_zero !== e.dz) begin n_err++; $display("FAIL %s_dz: got %b want %b", name, div_by_zero, e.dz); end
        @(negedge clk);
        n_cmp++; if ({done, div_by_zero} !== 5'b0) begin n_err++; $display("FAIL %s_pulse_len: got %b want 00000", name, {done, div_by_zero}); end
    endtask

    task automatic test_signed();
        test_single_op(2, -100, 7, "neg_pos");
        test_single_op(2, 100, -7, "pos_neg");
        test_single_op(2, -100, -7, "neg_neg");
        test_single_op(2, -128, -1, "overflow");
        test_single_op(2, 0, 5, "zero_dvd");
        test_single_op(2, -128, 1, "min_by_one");
        test_single_op(2, 127, -128, "small_quot");
    endtask

    task automatic test_div_zero();
        test_single_op(1, 37, 0, "div_zero");
    endtask

    // All four threads request together; grants must come out 0,1,2,3
    task automatic test_back_to_back();
        exp_t         e;
        int           seen, cyc, last;
        logic [T-1:0] want;
        do_reset();
        load_op(0, 55, 5);
        load_op(1, -90, 4);
        load_op(2, 120, -11);
        load_op(3, -77, -3);
        req  = 4'b1111;
        seen = 0;
        cyc  = 0;
        last = 0;
        while (seen < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done !== 4'b0000) begin
                e           = sb.pop_front();
                want        = '0;
                want[e.thr] = 1'b1;
                n_cmp++; if (done !== want) begin n_err++; $display("FAIL rr_done%0d: got %b want %b", seen, done, want); end
                n_cmp++; if (grant_id !== 2'(e.thr)) begin n_err++; $display("FAIL rr_grant%0d: got %0d want %0d", seen, grant_id, e.thr); end
                n_cmp++; if (result !== e.res) begin n_err++; $display("FAIL rr_result%0d: got %h want %h", seen, result, e.res); end
                if (seen > 0) begin
                    n_cmp++; if (cyc - last !== 11) begin n_err++; $display("FAIL rr_period%0d: got %0d want 11", seen, cyc - last); end
                end
                last = cyc;
                req  = req & ~done;
                seen++;
            end
        end
        if (seen < 4) begin
            n_cmp++; n_err++;
            $display("FAIL rr_timeout: got %0d dones want 4", seen);
        end
        req = '0;
        sb.delete();
    endtask

    // Threads 0 and 2 keep requesting; service must alternate
    task automatic test_fairness();
        exp_t         e;
        int           seen, cyc;
        do_reset();
        load_op(0, 99, 9);
        load_op(2, -64, 8);
        load_op(0, 99, 9);
        load_op(2, -64, 8);
        req  = 4'b0101;
        seen = 0;
        cyc  = 0;
        while (seen < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done !== 4'b0000) begin
                e = sb.pop_front();
                n_cmp++; if (grant_id !== 2'(e.thr)) begin n_err++; $display("FAIL fair_grant%0d: got %0d want %0d", seen, grant_id, e.thr); end
                n_cmp++; if (result !== e.res) begin n_err++; $display("FAIL fair_result%0d: got %h want %h", seen, result, e.res); end
                seen++;
                if (seen == 4) req = '0;
            end
        end
        if (seen < 4) begin
            n_cmp++; n_err++;
            $display("FAIL fair_timeout: got %0d dones want 4", seen);
        end
        req = '0;
        sb.delete();
    endtask

    // Abort in the 4th DIVIDE cycle; round-robin pointer must restart at 0
    task automatic test_reset_mid_op();
        exp_t e;
        int   cyc;
        logic [T-1:0] want;
        do_reset();
        dividend[1*W +: W] = 8'd50;
        divisor[1*W +: W]  = 8'd3;
        req = 4'b0010;
        @(negedge clk);           // cycle 1 (LOAD)
        req = '0;
        repeat (4) @(negedge clk); // cycles 2..5 (DIVIDE 1..4)
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL abort_done: got %b want 0000", done); end
        n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL abort_result: got %h want 00", result); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL abort_grant: got %0d want 0", grant_id); end
        reset = 1'b0;
        // Without the pointer reset a search from thread 2 would pick thread 2
        load_op(1, 50, 3);
        dividend[2*W +: W] = 8'd20;
        divisor[2*W +: W]  = 8'd4;
        req = 4'b0110;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done !== 4'b0000) break;
        end
        req = '0;
        if (done === 4'b0000) begin
            n_cmp++; n_err++;
            $display("FAIL abort_regrant_timeout: got no done want done within 20 cycles");
        end else begin
            e           = sb.pop_front();
            want        = '0;
            want[e.thr] = 1'b1;
            n_cmp++; if (done !== want) begin n_err++; $display("FAIL abort_regrant_done: got %b want %b", done, want); end
            n_cmp++; if (grant_id !== 2'(e.thr)) begin n_err++; $display("FAIL abort_regrant_id: got %0d want %0d", grant_id, e.thr); end
            n_cmp++; if (result !== e.res) begin n_err++; $display("FAIL abort_regrant_result: got %h want %h", result, e.res); end
        end
        sb.delete();
        do_reset();
        load_op(2, 21, 4);
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL post_reset_grant2: got %0d want 2", grant_id); end
        repeat (12) @(negedge clk);
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_fairness();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
